seq_insert: RTL and testbench

Transmit-side framing stage for the Aurora AXI-Stream link. It sits between the user AXI-Stream source and the Aurora TX user interface, and it is the counterpart of the receive-side stage that strips sequence numbers. When enabled, it appends one 32-bit sequence-number word to every frame and moves `tlast` onto that word. It also counts transmitted frames for status readout.

---
 rtl/seq_insert.sv | 130 +++++++++++++
 tb/tb_seq_insert.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_insert.sv
// seq_insert: transmit-side framing stage for the Aurora AXI-Stream link.
// When enabled, it appends one 32-bit sequence word to every frame and moves
// tlast onto that word. It also counts frames completed on the master side.
module seq_insert #(
  parameter logic [31:0] SEQ_INIT = 32'h0000_0001
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        ctrl_seq_en,
  input  logic        ctrl_rst_cntr_out,
  output logic [63:0] slv_cntr_out
);

  typedef enum logic {
    ST_PASS,
    ST_SEQ
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_inFrame;
  logic        r_seqEnQ;
  logic [31:0] r_seq;

  logic w_slotFree;
  logic w_effEn;
  logic w_inAccept;
  logic w_outHandshake;
  logic w_loadSeq;

  // The output register can take a new word when empty or being drained.
  assign w_slotFree     = !m_axis_tvalid || m_axis_tready;
  // The enable seen by a beat is frozen for the rest of its frame.
  assign w_effEn        = r_inFrame ? r_seqEnQ : ctrl_seq_en;
  assign s_axis_tready  = w_slotFree && (r_state == ST_PASS) && s_axis_aresetn;
  assign w_inAccept     = s_axis_tvalid && s_axis_tready;
  assign w_outHandshake = m_axis_tvalid && m_axis_tready;

  // Next-state logic: enter ST_SEQ after an enabled last beat, leave once the word is loaded.
  always_comb begin
    w_stateNext = r_state;
    w_loadSeq   = 1'b0;
    case (r_state)
      ST_PASS: begin
        if (w_inAccept && s_axis_tlast && w_effEn) begin
          w_stateNext = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (w_slotFree) begin
          w_loadSeq   = 1'b1;
          w_stateNext = ST_PASS;
        end
      end
      default: begin
        w_stateNext = ST_PASS;
      end
    endcase
  end

  // State register.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      r_state <= ST_PASS;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Output register: load a user beat or a sequence word, otherwise drop valid once drained.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 32'd0;
      m_axis_tlast  <= 1'b0;
    end else if (w_inAccept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tlast  <= s_axis_tlast && !w_effEn;
    end else if (w_loadSeq) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= r_seq;
      m_axis_tlast  <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Frame tracking: capture the enable on the first beat of each frame.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      r_inFrame <= 1'b0;
      r_seqEnQ  <= 1'b0;
    end else if (w_inAccept) begin
      if (!r_inFrame) begin
        r_seqEnQ <= ctrl_seq_en;
      end
      r_inFrame <= !s_axis_tlast;
    end
  end

  // Sequence counter advances only when a sequence word enters the output register.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      r_seq <= SEQ_INIT;
    end else if (w_loadSeq) begin
      r_seq <= r_seq + 32'd1;
    end
  end

  // Frame counter: clear wins over a coinciding end-of-frame handshake.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      slv_cntr_out <= 64'd0;
    end else if (ctrl_rst_cntr_out) begin
      slv_cntr_out <= 64'd0;
    end else if (w_outHandshake && m_axis_tlast) begin
      slv_cntr_out <= slv_cntr_out + 64'd1;
    end
  end

endmodule

// File: tb/tb_seq_insert.sv
// tb_seq_insert: drives two seq_insert instances (default and near-wrap SEQ_INIT)
// with identical stimulus and compares them against a queue-based frame model.
module tb_seq_insert;

  localparam logic [31:0] INIT_A = 32'h0000_0001;
  localparam logic [31:0] INIT_B = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic        sValid;
  logic [31:0] sData;
  logic        sLast;
  logic        mReady;
  logic        seqEn;
  logic        rstCntr;

  logic        sReadyA, mValidA, mLastA;
  logic [31:0] mDataA;
  logic [63:0] cntA;
  logic        sReadyB, mValidB, mLastB;
  logic [31:0] mDataB;
  logic [63:0] cntB;

  seq_insert #(.SEQ_INIT(INIT_A)) dutA (
    .s_axis_aclk(clk), .s_axis_aresetn(aresetn),
    .s_axis_tvalid(sValid), .s_axis_tready(sReadyA),
    .s_axis_tdata(sData), .s_axis_tlast(sLast),
    .m_axis_tvalid(mValidA), .m_axis_tready(mReady),
    .m_axis_tdata(mDataA), .m_axis_tlast(mLastA),
    .ctrl_seq_en(seqEn), .ctrl_rst_cntr_out(rstCntr),
    .slv_cntr_out(cntA)
  );

  seq_insert #(.SEQ_INIT(INIT_B)) dutB (
    .s_axis_aclk(clk), .s_axis_aresetn(aresetn),
    .s_axis_tvalid(sValid), .s_axis_tready(sReadyB),
    .s_axis_tdata(sData), .s_axis_tlast(sLast),
    .m_axis_tvalid(mValidB), .m_axis_tready(mReady),
    .m_axis_tdata(mDataB), .m_axis_tlast(mLastB),
    .ctrl_seq_en(seqEn), .ctrl_rst_cntr_out(rstCntr),
    .slv_cntr_out(cntB)
  );

  // Model item: isSeq items carry the sequence index (0,1,2..) in data.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        isSeq;
  } item_t;

  typedef struct packed {
    logic [31:0] dA;
    logic [31:0] dB;
    logic        last;
  } cap_t;

  typedef struct packed {
    logic        sValid;
    logic [31:0] sData;
    logic        sLast;
    logic        mReady;
    logic        seqEn;
    logic        expMValid;
    logic [31:0] expMData;
    logic        expMLast;
    logic        expSReady;
    logic [63:0] expCnt;
  } vec_t;

  item_t       expQ[$];
  cap_t        capQ[$];
  logic        mrPat[$];
  logic [31:0] seqIdx = 32'd0;
  logic        mdlInFrame = 1'b0;
  logic        mdlEnQ = 1'b0;
  logic [63:0] mdlCnt = 64'd0;
  logic        rstnDrive = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic mdlReady();
    return aresetn && (expQ.size() == 0 || (expQ.size() == 1 && mReady));
  endfunction

  function automatic logic [31:0] expData(input item_t it, input logic [31:0] init);
    return it.isSeq ? init + it.data : it.data;
  endfunction

  function automatic logic nextMr();
    if (mrPat.size() > 0) return mrPat.pop_front();
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the model and record output handshakes.
  task automatic checkOutput();
    item_t h;
    logic  expV;
    expV = (expQ.size() > 0);
    chk("m_tvalid_a", 64'(mValidA), 64'(expV));
    chk("m_tvalid_b", 64'(mValidB), 64'(expV));
    chk("s_tready_a", 64'(sReadyA), 64'(mdlReady()));
    chk("s_tready_b", 64'(sReadyB), 64'(mdlReady()));
    chk("cntr_a", cntA, mdlCnt);
    chk("cntr_b", cntB, mdlCnt);
    if (expV) begin
      h = expQ[0];
      chk("m_tdata_a", 64'(mDataA), 64'(expData(h, INIT_A)));
      chk("m_tdata_b", 64'(mDataB), 64'(expData(h, INIT_B)));
      chk("m_tlast_a", 64'(mLastA), 64'(h.last));
      chk("m_tlast_b", 64'(mLastB), 64'(h.last));
    end
    if (mValidA && mReady) capQ.push_back({mDataA, mDataB, mLastA});
  endtask

  // Advance the model across one rising edge using the inputs in force.
  task automatic modelStep();
    logic inHs, outHs, eff;
    if (!aresetn) begin
      expQ.delete();
      seqIdx = 32'd0;
      mdlInFrame = 1'b0;
      mdlEnQ = 1'b0;
      mdlCnt = 64'd0;
    end else begin
      inHs  = sValid && mdlReady();
      outHs = (expQ.size() > 0) && mReady;
      if (rstCntr) mdlCnt = 64'd0;
      else if (outHs && expQ[0].last) mdlCnt = mdlCnt + 64'd1;
      if (outHs) void'(expQ.pop_front());
      if (inHs) begin
        eff = mdlInFrame ? mdlEnQ : seqEn;
        if (!mdlInFrame) mdlEnQ = seqEn;
        mdlInFrame = !sLast;
        expQ.push_back({sData, sLast && !eff, 1'b0});
        if (sLast && eff) begin
          expQ.push_back({seqIdx, 1'b1, 1'b1});
          seqIdx = seqIdx + 32'd1;
        end
      end
    end
  endtask

  task automatic driveCycle(input logic v, input logic [31:0] d, input logic l,
                            input logic mr, input logic en, input logic rc);
    @(negedge clk);
    aresetn = rstnDrive;
    sValid  = v;
    sData   = d;
    sLast   = l;
    mReady  = mr;
    seqEn   = en;
    rstCntr = rc;
    #1;
    checkOutput();
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelStep();
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l,
                               input logic mr, input logic en, input logic rc);
    driveCycle(v, d, l, mr, en, rc);
    finishCycle();
  endtask

  task automatic sendBeat(input logic [31:0] d, input logic l, input logic en);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 50; n++) begin
      driveCycle(1'b1, d, l, nextMr(), en, 1'b0);
      acc = sReadyA;
      finishCycle();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && expQ.size() > 0; n++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, nextMr(), seqEn, 1'b0);
    end
    chk("drain_timeout", 64'(expQ.size()), 64'd0);
  endtask

  task automatic doReset();
    rstnDrive = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveCycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("rst_s_tready", 64'(sReadyA), 64'd0);
      if (i > 0) begin
        chk("rst_m_tvalid", 64'(mValidA), 64'd0);
        chk("rst_m_tdata", 64'(mDataA), 64'd0);
        chk("rst_m_tlast", 64'(mLastA), 64'd0);
        chk("rst_cntr", cntA, 64'd0);
      end
      finishCycle();
    end
    rstnDrive = 1'b1;
  endtask

  task automatic checkCap(input int idx, input logic [31:0] dA, input logic [31:0] dB, input logic l);
    if (idx >= capQ.size()) begin
      chk("cap_missing", 64'(capQ.size()), 64'(idx + 1));
    end else begin
      chk("cap_data_a", 64'(capQ[idx].dA), 64'(dA));
      chk("cap_data_b", 64'(capQ[idx].dB), 64'(dB));
      chk("cap_last", 64'(capQ[idx].last), 64'(l));
    end
  endtask

  vec_t tbl[6];

  initial begin
    aresetn = 1'b0; sValid = 1'b1; sData = 32'd0; sLast = 1'b0;
    mReady = 1'b1; seqEn = 1'b1; rstCntr = 1'b0;

    // One enabled frame straight out of reset (DUT A, SEQ_INIT=1).
    tbl[0] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 64'd0};
    tbl[1] = '{1'b1, 32'h5AA55AA5, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 64'd0};
    tbl[2] = '{1'b1, 32'h00000007, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5AA55AA5, 1'b0, 1'b1, 64'd0};
    tbl[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h00000007, 1'b0, 1'b0, 64'd0};
    tbl[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b1, 64'd0};
    tbl[5] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 64'd1};

    doReset();
    for (int i = 0; i < 6; i++) begin
      driveCycle(tbl[i].sValid, tbl[i].sData, tbl[i].sLast, tbl[i].mReady, tbl[i].seqEn, 1'b0);
      chk("tbl_m_tvalid", 64'(mValidA), 64'(tbl[i].expMValid));
      if (tbl[i].expMValid) begin
        chk("tbl_m_tdata", 64'(mDataA), 64'(tbl[i].expMData));
        chk("tbl_m_tlast", 64'(mLastA), 64'(tbl[i].expMLast));
      end
      chk("tbl_s_tready", 64'(sReadyA), 64'(tbl[i].expSReady));
      chk("tbl_cntr", cntA, tbl[i].expCnt);
      finishCycle();
    end

    // Back-to-back single-beat frames; DUT B wraps FFFFFFFE -> 0.
    doReset();
    capQ.delete();
    sendBeat(32'h11, 1'b1, 1'b1);
    sendBeat(32'h22, 1'b1, 1'b1);
    sendBeat(32'h33, 1'b1, 1'b1);
    drain();
    chk("b2b_len", 64'(capQ.size()), 64'd6);
    checkCap(0, 32'h11, 32'h11, 1'b0);
    checkCap(1, 32'h1, 32'hFFFFFFFE, 1'b1);
    checkCap(2, 32'h22, 32'h22, 1'b0);
    checkCap(3, 32'h2, 32'hFFFFFFFF, 1'b1);
    checkCap(4, 32'h33, 32'h33, 1'b0);
    checkCap(5, 32'h3, 32'h0, 1'b1);
    driveCycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("b2b_cntr", cntA, 64'd3);
    finishCycle();

    // Counter clear coinciding with the final tlast handshake.
    sendBeat(32'h44, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    driveCycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_at_last", 64'({mValidA, mLastA}), 64'd3);
    finishCycle();
    driveCycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_cntr", cntA, 64'd0);
    finishCycle();

    // Backpressure during a 4-beat enabled frame.
    doReset();
    capQ.delete();
    mrPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sendBeat(32'h100, 1'b0, 1'b1);
    sendBeat(32'h101, 1'b0, 1'b1);
    sendBeat(32'h102, 1'b0, 1'b1);
    sendBeat(32'h103, 1'b1, 1'b1);
    drain();
    chk("bp_len", 64'(capQ.size()), 64'd5);
    checkCap(0, 32'h100, 32'h100, 1'b0);
    checkCap(1, 32'h101, 32'h101, 1'b0);
    checkCap(2, 32'h102, 32'h102, 1'b0);
    checkCap(3, 32'h103, 32'h103, 1'b0);
    checkCap(4, 32'h1, 32'hFFFFFFFE, 1'b1);

    // Enable dropped on beat 2: current frame keeps its word, next frame passes through.
    doReset();
    capQ.delete();
    sendBeat(32'h200, 1'b0, 1'b1);
    sendBeat(32'h201, 1'b0, 1'b0);
    sendBeat(32'h202, 1'b1, 1'b0);
    sendBeat(32'h210, 1'b0, 1'b0);
    sendBeat(32'h211, 1'b1, 1'b0);
    sendBeat(32'h220, 1'b1, 1'b1);
    drain();
    chk("en_len", 64'(capQ.size()), 64'd8);
    checkCap(2, 32'h202, 32'h202, 1'b0);
    checkCap(3, 32'h1, 32'hFFFFFFFE, 1'b1);
    checkCap(4, 32'h210, 32'h210, 1'b0);
    checkCap(5, 32'h211, 32'h211, 1'b1);
    checkCap(6, 32'h220, 32'h220, 1'b0);
    checkCap(7, 32'h2, 32'hFFFFFFFF, 1'b1);

    // Random traffic including stalls, enable toggles, counter clears and resets.
    for (int n = 0; n < 3000; n++) begin
      rstnDrive = ($urandom_range(0, 299) != 0);
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 31) == 0);
    end
    rstnDrive = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
